// File: rtl/win_pkg.sv
// Shared definitions for the window sequencers.
//   state_t  : sequencer states (IDLE, FILL, RUN, DRAIN)
//   WIN_SIZE : window edge length in pixels
//   WIN_HALF : offset from the window's bottom-right pixel to its centre
//   cnt_w()  : bit width needed to hold a raster index 0..n-1
package win_pkg;

    localparam int unsigned WIN_SIZE = 11;
    localparam int unsigned WIN_HALF = 5;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_11x11_ctrl_if.sv
// Handshake/status bundle between the window sequencer and its neighbours.
//   start_i, pix_valid_i             : requests into the sequencer
//   buf_en_o                         : window buffer shift enable
//   win_valid_o, center_row_o/col_o  : complete-window flag and its centre
//   frame_done_o, busy_o, drop_o     : frame status
// slave = sequencer side, master = driver/monitor side.
interface window_11x11_ctrl_if #(
    parameter int unsigned COLS = 13,
    parameter int unsigned ROWS = 13
);

    localparam int unsigned RW = win_pkg::cnt_w(ROWS);
    localparam int unsigned CW = win_pkg::cnt_w(COLS);

    logic          start_i;
    logic          pix_valid_i;
    logic          buf_en_o;
    logic          win_valid_o;
    logic [RW-1:0] center_row_o;
    logic [CW-1:0] center_col_o;
    logic          frame_done_o;
    logic          busy_o;
    logic          drop_o;

    modport slave (
        input  start_i, pix_valid_i,
        output buf_en_o, win_valid_o, center_row_o, center_col_o,
               frame_done_o, busy_o, drop_o
    );

    modport master (
        output start_i, pix_valid_i,
        input  buf_en_o, win_valid_o, center_row_o, center_col_o,
               frame_done_o, busy_o, drop_o
    );

endinterface

// File: rtl/raster_counter.sv
// Raster position counter: col advances on en, wrapping into the next row;
// the whole counter wraps to (0,0) after the last pixel.
//   clk, rst  : clock, synchronous active-low reset
//   en        : advance one position
//   clr       : return to (0,0); has priority over en
//   row, col  : current position
//   last_col  : col is COLS-1
//   last_pix  : position is (ROWS-1, COLS-1)
module raster_counter #(
    parameter int unsigned COLS = 13,
    parameter int unsigned ROWS = 13
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              clr,
    output logic [win_pkg::cnt_w(ROWS)-1:0]   row,
    output logic [win_pkg::cnt_w(COLS)-1:0]   col,
    output logic                              last_col,
    output logic                              last_pix
);

    localparam int unsigned RW = win_pkg::cnt_w(ROWS);
    localparam int unsigned CW = win_pkg::cnt_w(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (en) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    assign row      = r_row;
    assign col      = r_col;
    assign last_col = (r_col == COL_LAST);
    assign last_pix = (r_col == COL_LAST) && (r_row == ROW_LAST);

endmodule

// File: rtl/window_11x11_ctrl.sv
// Sequencer for the 11x11 window buffer. Counts accepted columns in raster
// order, gates the buffer shift, and tags each accept with "window complete",
// the window centre and "last column of frame"; the tags travel through a
// WIN_LAT-deep delay line so they line up with the buffer outputs.
//   clk, rst : clock, synchronous active-low reset
//   bus      : handshake/status bundle (slave side), see window_11x11_ctrl_if
module window_11x11_ctrl
    import win_pkg::*;
#(
    parameter int unsigned COLS    = 13,
    parameter int unsigned ROWS    = 13,
    parameter int unsigned WIN_LAT = 1
) (
    input logic                 clk,
    input logic                 rst,
    window_11x11_ctrl_if.slave  bus
);

    localparam int unsigned RW = cnt_w(ROWS);
    localparam int unsigned CW = cnt_w(COLS);
    // FILL ends on the last column of the row just above the first full window
    localparam logic [RW-1:0] FILL_ROW  = RW'(WIN_SIZE - 2);
    localparam logic [RW-1:0] FIRST_ROW = RW'(WIN_SIZE - 1);
    localparam logic [CW-1:0] FIRST_COL = CW'(WIN_SIZE - 1);

    state_t r_state, w_next;

    logic          w_in_frame, w_accept, w_complete, w_last, w_clr;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic          w_last_col, w_last_pix;

    logic [WIN_LAT-1:0] r_cplt;
    logic [WIN_LAT-1:0] r_last;
    logic [RW-1:0]      r_crow [WIN_LAT];
    logic [CW-1:0]      r_ccol [WIN_LAT];

    // rst gating keeps every combinational output low while reset is held
    assign w_in_frame = rst && ((r_state == FILL) || (r_state == RUN));
    assign w_accept   = w_in_frame && bus.pix_valid_i;
    assign w_complete = w_accept && (w_row >= FIRST_ROW) && (w_col >= FIRST_COL);
    assign w_last     = w_accept && w_last_pix;
    assign w_clr      = (r_state == IDLE);

    raster_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (w_accept),
        .clr      (w_clr),
        .row      (w_row),
        .col      (w_col),
        .last_col (w_last_col),
        .last_pix (w_last_pix)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start_i) w_next = FILL;
            FILL:    if (w_accept && (w_row == FILL_ROW) && w_last_col) w_next = RUN;
            RUN:     if (w_last) w_next = DRAIN;
            DRAIN:   if (r_last[WIN_LAT-1]) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Stages not loaded by a complete window carry zero tags, so the
    // outputs pulse rather than hold across stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cplt <= '0;
            r_last <= '0;
            for (int unsigned i = 0; i < WIN_LAT; i++) begin
                r_crow[i] <= '0;
                r_ccol[i] <= '0;
            end
        end else begin
            r_cplt[0] <= w_complete;
            r_last[0] <= w_last;
            r_crow[0] <= w_complete ? (w_row - RW'(WIN_HALF)) : '0;
            r_ccol[0] <= w_complete ? (w_col - CW'(WIN_HALF)) : '0;
            for (int unsigned i = 1; i < WIN_LAT; i++) begin
                r_cplt[i] <= r_cplt[i-1];
                r_last[i] <= r_last[i-1];
                r_crow[i] <= r_crow[i-1];
                r_ccol[i] <= r_ccol[i-1];
            end
        end
    end

    assign bus.buf_en_o     = w_accept;
    assign bus.drop_o       = rst && bus.pix_valid_i &&
                              ((r_state == IDLE) || (r_state == DRAIN));
    assign bus.busy_o       = rst && (r_state != IDLE);
    assign bus.win_valid_o  = r_cplt[WIN_LAT-1];
    assign bus.frame_done_o = r_last[WIN_LAT-1];
    assign bus.center_row_o = r_crow[WIN_LAT-1];
    assign bus.center_col_o = r_ccol[WIN_LAT-1];

endmodule

// File: tb/tb_window_11x11_ctrl.sv
// Self-checking bench for window_11x11_ctrl: a default 13x13/LAT=1 instance
// checked cycle by cycle against a raster-index reference model, plus a
// 16x11/LAT=3 instance checked on a single frame.
module tb_window_11x11_ctrl;

    localparam int COLS = 13, ROWS = 13, WIN_LAT = 1, TOTAL = COLS * ROWS;
    localparam int RA = $clog2(ROWS), CA = $clog2(COLS);
    localparam int B_COLS = 16, B_ROWS = 11, B_LAT = 3, B_TOTAL = B_COLS * B_ROWS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    window_11x11_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) ifa ();
    window_11x11_ctrl_if #(.COLS(B_COLS), .ROWS(B_ROWS)) ifb ();

    window_11x11_ctrl #(.COLS(COLS), .ROWS(ROWS), .WIN_LAT(WIN_LAT)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    window_11x11_ctrl #(.COLS(B_COLS), .ROWS(B_ROWS), .WIN_LAT(B_LAT)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    // Reference model: a frame is "the n-th accepted column sits at
    // (n / COLS, n % COLS)"; a window exists once an 11x11 block ending there
    // fits in the image, and it appears WIN_LAT cycles after its column.
    typedef struct { int cyc; int row; int col; bit wv; bit last; } ev_t;
    ev_t q[$];
    int  cyc, m_n, m_end;
    bit  m_busy;

    int n_cmp = 0, n_err = 0;
    int n_win, n_fd, n_drop, n_acc, first_acc;
    int obs_r[$], obs_c[$];

    task automatic clr_stats();
        n_win = 0; n_fd = 0; n_drop = 0; n_acc = 0; first_acc = -1;
        obs_r.delete(); obs_c.delete();
    endtask

    // One clock cycle on instance A: drive, compare at negedge, advance model.
    task automatic step(input bit rv, input bit st, input bit pv);
        bit in_frame, e_buf, e_drop, e_busy, e_wv, e_fd, hit;
        int r, c;
        logic [RA-1:0] xr;
        logic [CA-1:0] xc;
        rst = rv; ifa.start_i = st; ifa.pix_valid_i = pv;
        in_frame = rv && m_busy && (m_n < TOTAL);
        e_buf  = pv && in_frame;
        e_drop = rv && pv && !in_frame;
        e_busy = rv && m_busy;
        hit  = (q.size() > 0) && (q[0].cyc == cyc);
        e_wv = hit && q[0].wv;
        e_fd = hit && q[0].last;
        xr = hit ? RA'(q[0].row) : '0;
        xc = hit ? CA'(q[0].col) : '0;
        @(negedge clk);
        n_cmp++; if (ifa.buf_en_o !== e_buf) begin n_err++;
            $display("FAIL buf_en cyc=%0d: got %b expected %b", cyc, ifa.buf_en_o, e_buf); end
        n_cmp++; if (ifa.drop_o !== e_drop) begin n_err++;
            $display("FAIL drop cyc=%0d: got %b expected %b", cyc, ifa.drop_o, e_drop); end
        n_cmp++; if (ifa.busy_o !== e_busy) begin n_err++;
            $display("FAIL busy cyc=%0d: got %b expected %b", cyc, ifa.busy_o, e_busy); end
        n_cmp++; if (ifa.win_valid_o !== e_wv) begin n_err++;
            $display("FAIL win_valid cyc=%0d: got %b expected %b", cyc, ifa.win_valid_o, e_wv); end
        n_cmp++; if (ifa.frame_done_o !== e_fd) begin n_err++;
            $display("FAIL frame_done cyc=%0d: got %b expected %b", cyc, ifa.frame_done_o, e_fd); end
        if (e_wv) begin
            n_cmp++; if (ifa.center_row_o !== xr || ifa.center_col_o !== xc) begin n_err++;
                $display("FAIL centre cyc=%0d: got (%0d,%0d) expected (%0d,%0d)",
                         cyc, ifa.center_row_o, ifa.center_col_o, xr, xc); end
        end
        if (ifa.win_valid_o === 1'b1) begin
            n_win++; obs_r.push_back(int'(ifa.center_row_o)); obs_c.push_back(int'(ifa.center_col_o));
            if (first_acc < 0) first_acc = n_acc;
        end
        if (ifa.frame_done_o === 1'b1) n_fd++;
        if (ifa.drop_o === 1'b1) n_drop++;
        if (ifa.buf_en_o === 1'b1) n_acc++;
        if (hit) void'(q.pop_front());
        if (!rv) begin
            q.delete(); m_busy = 0; m_n = 0;
        end else begin
            if (pv && in_frame) begin
                r = m_n / COLS; c = m_n % COLS;
                if ((r >= 10 && c >= 10) || m_n == TOTAL - 1)
                    q.push_back('{cyc + WIN_LAT, r - 5, c - 5, (r >= 10 && c >= 10), m_n == TOTAL - 1});
                m_n++;
                if (m_n == TOTAL) m_end = cyc + WIN_LAT;
            end
            if (!m_busy) begin
                if (st) begin m_busy = 1; m_n = 0; end
            end else if (m_n == TOTAL && cyc == m_end) begin
                m_busy = 0;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset();
        clr_stats();
        step(1'b0, 1'b1, 1'b1);
        n_cmp++; if (ifa.busy_o !== 1'b0 || ifa.win_valid_o !== 1'b0 || ifa.frame_done_o !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs: got busy=%b wv=%b fd=%b expected 0 0 0",
                              ifa.busy_o, ifa.win_valid_o, ifa.frame_done_o); end
        n_cmp++; if (ifa.buf_en_o !== 1'b0 || ifa.drop_o !== 1'b0) begin
            n_err++; $display("FAIL reset_buf_en: got buf_en=%b drop=%b expected 0 0",
                              ifa.buf_en_o, ifa.drop_o); end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_full_frame();
        int k;
        clr_stats();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < TOTAL; i++) step(1'b1, 1'b0, 1'b1);
        repeat (WIN_LAT + 2) step(1'b1, 1'b0, 1'b0);
        n_cmp++; if (n_win !== 9) begin n_err++; $display("FAIL full_windows: got %0d expected 9", n_win); end
        n_cmp++; if (n_fd !== 1) begin n_err++; $display("FAIL full_done: got %0d expected 1", n_fd); end
        n_cmp++; if (first_acc !== 141) begin n_err++;
            $display("FAIL full_first: got %0d expected 141", first_acc); end
        k = 0;
        for (int r = 5; r <= ROWS - 6; r++)
            for (int c = 5; c <= COLS - 6; c++) begin
                n_cmp++;
                if (k >= obs_r.size() || obs_r[k] != r || obs_c[k] != c) begin n_err++;
                    $display("FAIL full_centre[%0d]: got (%0d,%0d) expected (%0d,%0d)", k,
                             (k < obs_r.size()) ? obs_r[k] : -1, (k < obs_c.size()) ? obs_c[k] : -1, r, c); end
                k++;
            end
        n_cmp++; if (ifa.busy_o !== 1'b0) begin n_err++; $display("FAIL full_idle: got busy=%b expected 0", ifa.busy_o); end
    endtask

    task automatic test_stall_toggle();
        int k;
        clr_stats();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 1000 && m_n < TOTAL; i++) step(1'b1, 1'b0, (i % 2) == 0);
        repeat (WIN_LAT + 2) step(1'b1, 1'b0, 1'b0);
        n_cmp++; if (n_acc !== TOTAL) begin n_err++; $display("FAIL stall_accepts: got %0d expected %0d", n_acc, TOTAL); end
        n_cmp++; if (n_win !== 9 || n_fd !== 1) begin n_err++;
            $display("FAIL stall_counts: got %0d/%0d expected 9/1", n_win, n_fd); end
        n_cmp++; if (first_acc !== 141) begin n_err++;
            $display("FAIL stall_first: got %0d expected 141", first_acc); end
        k = 0;
        for (int r = 5; r <= ROWS - 6; r++)
            for (int c = 5; c <= COLS - 6; c++) begin
                n_cmp++;
                if (k >= obs_r.size() || obs_r[k] != r || obs_c[k] != c) begin n_err++;
                    $display("FAIL stall_centre[%0d]: got (%0d,%0d) expected (%0d,%0d)", k,
                             (k < obs_r.size()) ? obs_r[k] : -1, (k < obs_c.size()) ? obs_c[k] : -1, r, c); end
                k++;
            end
    endtask

    task automatic test_idle_drop();
        clr_stats();
        repeat (3) step(1'b1, 1'b0, 1'b1);
        n_cmp++; if (n_drop !== 3 || n_acc !== 0) begin n_err++;
            $display("FAIL idle_drop: got drops=%0d accepts=%0d expected 3 0", n_drop, n_acc); end
        step(1'b1, 1'b1, 1'b1);   // start and column together: column dropped
        for (int i = 0; i < TOTAL; i++) step(1'b1, 1'b0, 1'b1);
        repeat (WIN_LAT + 2) step(1'b1, 1'b0, 1'b0);
        n_cmp++; if (n_drop !== 4) begin n_err++; $display("FAIL start_drop: got %0d expected 4", n_drop); end
        n_cmp++; if (first_acc !== 141 || n_win !== 9) begin n_err++;
            $display("FAIL drop_frame: got first=%0d windows=%0d expected 141 9", first_acc, n_win); end
    endtask

    task automatic test_reset_abort();
        clr_stats();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 150; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        repeat (WIN_LAT + 3) step(1'b1, 1'b0, 1'b0);
        n_cmp++; if (n_fd !== 0 || n_win !== 3) begin n_err++;
            $display("FAIL abort_counts: got done=%0d windows=%0d expected 0 3", n_fd, n_win); end
        n_cmp++; if (ifa.busy_o !== 1'b0) begin n_err++; $display("FAIL abort_idle: got busy=%b expected 0", ifa.busy_o); end
        clr_stats();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < TOTAL; i++) step(1'b1, 1'b0, 1'b1);
        repeat (WIN_LAT + 2) step(1'b1, 1'b0, 1'b0);
        n_cmp++; if (n_win !== 9 || n_fd !== 1) begin n_err++;
            $display("FAIL abort_next: got %0d/%0d expected 9/1", n_win, n_fd); end
        n_cmp++; if (obs_r.size() == 0 || obs_r[0] != 5 || obs_c[0] != 5) begin n_err++;
            $display("FAIL abort_first_centre: got (%0d,%0d) expected (5,5)",
                     (obs_r.size() > 0) ? obs_r[0] : -1, (obs_c.size() > 0) ? obs_c[0] : -1); end
    endtask

    task automatic test_back_to_back();
        clr_stats();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < TOTAL; i++) step(1'b1, 1'b0, 1'b1);
        repeat (WIN_LAT) step(1'b1, 1'b1, 1'b0);   // DRAIN: ignored
        step(1'b1, 1'b1, 1'b0);                    // first IDLE cycle: honoured
        for (int i = 0; i < 4000 && m_n < TOTAL; i++) step(1'b1, 1'b0, $urandom_range(0, 3) != 0);
        repeat (WIN_LAT + 2) step(1'b1, 1'b0, 1'b0);
        n_cmp++; if (n_acc !== 2 * TOTAL) begin n_err++;
            $display("FAIL b2b_accepts: got %0d expected %0d", n_acc, 2 * TOTAL); end
        n_cmp++; if (n_win !== 18 || n_fd !== 2) begin n_err++;
            $display("FAIL b2b_counts: got %0d/%0d expected 18/2", n_win, n_fd); end
    endtask

    task automatic test_alt_config();
        int acc, last_acc, fd_cyc, fd_win;
        int br[$], bc[$];
        acc = 0; last_acc = -1; fd_cyc = -1; fd_win = -1;
        ifa.start_i = 1'b0; ifa.pix_valid_i = 1'b0;
        ifb.start_i = 1'b1; ifb.pix_valid_i = 1'b0;
        @(posedge clk); #1;
        ifb.start_i = 1'b0;
        for (int j = 0; j < B_TOTAL + 8; j++) begin
            ifb.pix_valid_i = (j < B_TOTAL);
            @(negedge clk);
            if (ifb.buf_en_o === 1'b1) begin acc++; last_acc = j; end
            if (ifb.win_valid_o === 1'b1) begin
                br.push_back(int'(ifb.center_row_o)); bc.push_back(int'(ifb.center_col_o));
            end
            if (ifb.frame_done_o === 1'b1) begin fd_cyc = j; fd_win = br.size(); end
            @(posedge clk); #1;
        end
        ifb.pix_valid_i = 1'b0;
        n_cmp++; if (acc !== B_TOTAL) begin n_err++; $display("FAIL alt_accepts: got %0d expected %0d", acc, B_TOTAL); end
        n_cmp++; if (br.size() !== 6) begin n_err++; $display("FAIL alt_windows: got %0d expected 6", br.size()); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (k >= br.size() || br[k] != 5 || bc[k] != 5 + k) begin n_err++;
                $display("FAIL alt_centre[%0d]: got (%0d,%0d) expected (5,%0d)", k,
                         (k < br.size()) ? br[k] : -1, (k < bc.size()) ? bc[k] : -1, 5 + k); end
        end
        n_cmp++; if (fd_cyc !== last_acc + B_LAT || fd_win !== 6) begin n_err++;
            $display("FAIL alt_done: got cycle=%0d with %0d windows, expected cycle=%0d with 6",
                     fd_cyc, fd_win, last_acc + B_LAT); end
        n_cmp++; if (ifb.busy_o !== 1'b0) begin n_err++; $display("FAIL alt_idle: got busy=%b expected 0", ifb.busy_o); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifa.start_i = 1'b0; ifa.pix_valid_i = 1'b0;
        ifb.start_i = 1'b0; ifb.pix_valid_i = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0; m_n = 0; m_end = 0; m_busy = 0;
        test_reset();
        test_full_frame();
        test_stall_toggle();
        test_idle_drop();
        test_reset_abort();
        test_back_to_back();
        test_alt_config();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
